// File: rtl/dma_chan_sched_if.sv
// rtl/dma_chan_sched_if.sv - channel request, core handshake and gating signals of the DMA channel scheduler
interface dma_chan_sched_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*32-1:0] ch_src_addr;
    logic [NUM_CH*32-1:0] ch_dest_addr;
    logic [NUM_CH*32-1:0] ch_len;
    logic [NUM_CH-1:0]    ch_done;
    logic                 dma_start;
    logic [31:0]          dma_src_addr;
    logic [31:0]          dma_dest_addr;
    logic [31:0]          dma_transfer_len;
    logic                 dma_done;
    logic                 clk_en;
    logic                 power_on;
    logic                 busy;
    logic [2:0]           grant_id;

    modport slave (
        input  ch_req, ch_src_addr, ch_dest_addr, ch_len, dma_done,
        output ch_done, dma_start, dma_src_addr, dma_dest_addr, dma_transfer_len,
        output clk_en, power_on, busy, grant_id
    );

    modport master (
        output ch_req, ch_src_addr, ch_dest_addr, ch_len, dma_done,
        input  ch_done, dma_start, dma_src_addr, dma_dest_addr, dma_transfer_len,
        input  clk_en, power_on, busy, grant_id
    );
endinterface

// File: rtl/dma_chan_sched.sv
// rtl/dma_chan_sched.sv - round-robin DMA channel scheduler with core clock/power gating
module dma_chan_sched #(
    parameter int NUM_CH       = 4,
    parameter int CLK_IDLE_CYC = 50,
    parameter int PWR_IDLE_CYC = 200,
    parameter int PWR_UP_CYC   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_chan_sched_if.slave bus
);
    localparam int CW = $clog2(PWR_IDLE_CYC + 1);

    typedef enum logic [2:0] {
        S_OFF, S_WAKE, S_IDLE, S_REARM, S_ARB, S_START, S_BUSY, S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_inc;
    logic [2:0]          rr_q;
    logic [2:0]          grant_q;
    logic                busy_q;
    logic                power_on_q;
    logic                clk_en_q;
    logic                dma_start_q;
    logic [NUM_CH-1:0]   ch_done_q;
    logic [31:0]         src_q, dest_q, len_q;

    logic [7:0]          req_ext;
    logic [31:0]         src_a  [8];
    logic [31:0]         dest_a [8];
    logic [31:0]         len_a  [8];
    logic                win_found;
    logic [2:0]          win_idx;
    logic [3:0]          idx;
    logic                any_req;

    // Widen channel-indexed data to 8 entries so a 3-bit index is always in range.
    assign req_ext = 8'(bus.ch_req);
    for (genvar g = 0; g < 8; g++) begin : g_desc
        if (g < NUM_CH) begin : g_used
            assign src_a[g]  = bus.ch_src_addr[32*g +: 32];
            assign dest_a[g] = bus.ch_dest_addr[32*g +: 32];
            assign len_a[g]  = bus.ch_len[32*g +: 32];
        end else begin : g_unused
            assign src_a[g]  = '0;
            assign dest_a[g] = '0;
            assign len_a[g]  = '0;
        end
    end

    assign any_req = |bus.ch_req;
    assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + 4'(i);
            if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
            if (!win_found && req_ext[idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OFF;
            cnt         <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            power_on_q  <= 1'b0;
            clk_en_q    <= 1'b0;
            dma_start_q <= 1'b0;
            ch_done_q   <= '0;
            src_q       <= '0;
            dest_q      <= '0;
            len_q       <= '0;
        end else begin
            dma_start_q <= 1'b0;
            ch_done_q   <= '0;
            case (state)
                S_OFF: if (any_req) begin
                    state      <= S_WAKE;
                    cnt        <= '0;
                    power_on_q <= 1'b1;
                end
                S_WAKE: if (cnt == CW'(PWR_UP_CYC - 1)) begin
                    state    <= S_ARB;
                    clk_en_q <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
                S_IDLE: if (any_req) begin
                    if (clk_en_q) begin
                        state <= S_ARB;
                    end else begin
                        state    <= S_REARM;
                        clk_en_q <= 1'b1;
                    end
                end else if (cnt == CW'(PWR_IDLE_CYC - 1)) begin
                    state      <= S_OFF;
                    power_on_q <= 1'b0;
                    clk_en_q   <= 1'b0;
                end else begin
                    cnt      <= cnt_inc;
                    clk_en_q <= (cnt_inc < CW'(CLK_IDLE_CYC));
                end
                S_REARM: state <= S_ARB;
                S_ARB: if (win_found) begin
                    src_q   <= src_a[win_idx];
                    dest_q  <= dest_a[win_idx];
                    len_q   <= len_a[win_idx];
                    grant_q <= win_idx;
                    if (len_a[win_idx] == '0) begin
                        state     <= S_DONE;
                        ch_done_q <= NUM_CH'(1) << win_idx;
                        busy_q    <= 1'b0;
                    end else begin
                        state       <= S_START;
                        dma_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end else begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                S_START: state <= S_BUSY;
                S_BUSY: if (bus.dma_done) begin
                    state     <= S_DONE;
                    ch_done_q <= NUM_CH'(1) << grant_q;
                    busy_q    <= 1'b0;
                end
                S_DONE: begin
                    rr_q <= (grant_q == 3'(NUM_CH - 1)) ? 3'd0 : grant_q + 3'd1;
                    if (any_req) begin
                        state <= S_ARB;
                    end else begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

    assign bus.ch_done          = ch_done_q;
    assign bus.dma_start        = dma_start_q;
    assign bus.dma_src_addr     = src_q;
    assign bus.dma_dest_addr    = dest_q;
    assign bus.dma_transfer_len = len_q;
    assign bus.clk_en           = clk_en_q;
    assign bus.power_on         = power_on_q;
    assign bus.busy             = busy_q;
    assign bus.grant_id         = grant_q;
endmodule
